// File: rtl/ccip_intr_pkg.sv
// Shared CCI-P header types, interrupt FSM state and queue defaults for the
// user-interrupt responder.
package ccip_intr_pkg;

  localparam int INTR_FIFO_DEPTH    = 16;
  localparam int INTR_ALMFULL_SLACK = 8;

  typedef enum logic [3:0] {
    eREQ_WRLINE_I = 4'h0,
    eREQ_WRLINE_M = 4'h1,
    eREQ_WRPUSH_I = 4'h2,
    eREQ_WRFENCE  = 4'h4,
    eREQ_INTR     = 4'h6
  } t_ccip_c1_req;

  typedef enum logic [3:0] {
    eRSP_WRLINE  = 4'h0,
    eRSP_WRFENCE = 4'h4,
    eRSP_INTR    = 4'h6
  } t_ccip_c1_rsp;

  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic         sop;
    logic         rsvd1;
    logic [1:0]   cl_len;
    t_ccip_c1_req req_type;
    logic [5:0]   rsvd0;
    logic [41:0]  address;
    logic [15:0]  mdata;
  } t_ccip_c1_ReqMemHdr;

  // Same 80-bit footprint as the memory header; req_type sits at the same bits.
  typedef struct packed {
    logic [5:0]   rsvd2;
    logic [1:0]   vc_sel;
    logic [3:0]   rsvd1;
    t_ccip_c1_req req_type;
    logic [61:0]  rsvd0;
    logic [1:0]   id;
  } t_ccip_c1_ReqIntrHdr;

  typedef struct packed {
    logic [7:0]   rsvd1;
    t_ccip_c1_rsp resp_type;
    logic [13:0]  rsvd0;
    logic [1:0]   id;
  } t_ccip_c1_RspIntrHdr;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } t_intr_state;

  typedef logic [1:0] t_intr_id;

  function automatic t_ccip_c1_RspIntrHdr intr_rsp_hdr(input t_intr_id id);
    t_ccip_c1_RspIntrHdr h;
    h           = '0;
    h.resp_type = eRSP_INTR;
    h.id        = id;
    return h;
  endfunction

endpackage

// File: rtl/ccip_intr_fifo.sv
// Synchronous FIFO with fall-through read; a push on full is accepted only
// when a pop frees a slot in the same cycle.
module ccip_intr_fifo #(
  parameter int  DEPTH = 16,
  parameter int  WIDTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr;
  logic             rd;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd    = pop && !empty;
  assign wr    = push && (!full || rd);
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ccip_intr_responder.sv
// Snoops AFU c1 Tx for interrupt requests, raises one MSI-X request per queued
// ID and returns an eRSP_INTR response on c1 Rx, strictly one in flight.
module ccip_intr_responder
  import ccip_intr_pkg::*;
#(
  parameter int FIFO_DEPTH    = INTR_FIFO_DEPTH,
  parameter int ALMFULL_SLACK = INTR_ALMFULL_SLACK,
  parameter int VEC_W         = 8,
  parameter int VEC_BASE      = 0
) (
  input  logic                Clk_400,
  input  logic                SoftReset_n,
  input  logic                af2cp_c1_valid,
  input  t_ccip_c1_ReqMemHdr  af2cp_c1_hdr,
  output logic                c1TxAlmFull,
  output logic                msix_req,
  output logic [VEC_W-1:0]    msix_vector,
  input  logic                msix_ack,
  input  logic                rsp_stall,
  output logic                cp2af_c1_rspValid,
  output t_ccip_c1_RspIntrHdr cp2af_c1_hdr,
  output logic [31:0]         intr_cnt,
  output logic                ovf_err
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [VEC_W-1:0] VEC_BASE_V = VEC_W'(VEC_BASE);

  t_ccip_c1_ReqIntrHdr intr_hdr;
  logic                push;
  logic                pop;
  t_intr_id            fifo_dout;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  t_intr_state         state;
  t_intr_id            cur_id;
  logic                unused_hdr_bits;

  assign intr_hdr        = t_ccip_c1_ReqIntrHdr'(af2cp_c1_hdr);
  assign push            = af2cp_c1_valid && (intr_hdr.req_type == eREQ_INTR);
  assign pop             = (state == IDLE) && !fifo_empty;
  assign unused_hdr_bits = ^{intr_hdr.rsvd2, intr_hdr.vc_sel, intr_hdr.rsvd1, intr_hdr.rsvd0};

  ccip_intr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(t_intr_id))
  ) u_fifo (
    .clk   (Clk_400),
    .rst_n (SoftReset_n),
    .push  (push),
    .din   (intr_hdr.id),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // A push into a full queue is lost unless the FSM pops in the same cycle.
  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      c1TxAlmFull <= 1'b0;
      ovf_err     <= 1'b0;
    end else begin
      c1TxAlmFull <= (fifo_count >= CW'(FIFO_DEPTH - ALMFULL_SLACK));
      if (push && fifo_full && !pop) ovf_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state             <= IDLE;
      cur_id            <= '0;
      msix_req          <= 1'b0;
      msix_vector       <= '0;
      cp2af_c1_rspValid <= 1'b0;
      cp2af_c1_hdr      <= '0;
      intr_cnt          <= '0;
    end else begin
      cp2af_c1_rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur_id      <= fifo_dout;
            msix_vector <= VEC_BASE_V + VEC_W'(fifo_dout);
            msix_req    <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (msix_ack) begin
            msix_req <= 1'b0;
            state    <= RSP;
          end
        end
        RSP: begin
          if (!rsp_stall) begin
            cp2af_c1_rspValid <= 1'b1;
            cp2af_c1_hdr      <= intr_rsp_hdr(cur_id);
            intr_cnt          <= intr_cnt + 32'd1;
            state             <= IDLE;
          end
        end
        default: begin
          msix_req <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ccip_intr_responder.sv
// Directed scoreboard bench for ccip_intr_responder: expected response IDs are
// queued as interrupts are sent and popped as responses appear.
module tb_ccip_intr_responder;
  import ccip_intr_pkg::*;

  logic                Clk_400 = 1'b0;
  logic                SoftReset_n;
  logic                af2cp_c1_valid;
  t_ccip_c1_ReqMemHdr  af2cp_c1_hdr;
  logic                c1TxAlmFull;
  logic                msix_req;
  logic [7:0]          msix_vector;
  logic                msix_ack;
  logic                rsp_stall;
  logic                cp2af_c1_rspValid;
  t_ccip_c1_RspIntrHdr cp2af_c1_hdr;
  logic [31:0]         intr_cnt;
  logic                ovf_err;

  int       checks = 0;
  int       errors = 0;
  logic [1:0] exp_q[$];
  logic     auto_ack = 1'b0;
  logic     almfull_seen;
  logic     req_seen;

  always #5 Clk_400 = ~Clk_400;

  ccip_intr_responder #(
    .FIFO_DEPTH    (16),
    .ALMFULL_SLACK (8),
    .VEC_W         (8),
    .VEC_BASE      (4)
  ) dut (
    .Clk_400           (Clk_400),
    .SoftReset_n       (SoftReset_n),
    .af2cp_c1_valid    (af2cp_c1_valid),
    .af2cp_c1_hdr      (af2cp_c1_hdr),
    .c1TxAlmFull       (c1TxAlmFull),
    .msix_req          (msix_req),
    .msix_vector       (msix_vector),
    .msix_ack          (msix_ack),
    .rsp_stall         (rsp_stall),
    .cp2af_c1_rspValid (cp2af_c1_rspValid),
    .cp2af_c1_hdr      (cp2af_c1_hdr),
    .intr_cnt          (intr_cnt),
    .ovf_err           (ovf_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, score any response, then play host.
  task automatic tick();
    logic [1:0] e;
    @(posedge Clk_400);
    @(negedge Clk_400);
    if (cp2af_c1_rspValid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_id", 32'(cp2af_c1_hdr.id), 32'(e));
        check("rsp_type", 32'(cp2af_c1_hdr.resp_type), 32'(eRSP_INTR));
      end
    end
    if (auto_ack) msix_ack = (msix_req === 1'b1);
  endtask

  task automatic send(input logic is_intr, input logic [1:0] id);
    t_ccip_c1_ReqIntrHdr ih;
    t_ccip_c1_ReqMemHdr  mh;
    if (is_intr) begin
      ih          = '0;
      ih.req_type = eREQ_INTR;
      ih.id       = id;
      af2cp_c1_hdr = t_ccip_c1_ReqMemHdr'(ih);
    end else begin
      mh          = '0;
      mh.req_type = eREQ_WRLINE_I;
      mh.address  = {10'd0, $urandom()};
      mh.mdata    = 16'($urandom());
      af2cp_c1_hdr = mh;
    end
    af2cp_c1_valid = 1'b1;
    tick();
    af2cp_c1_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound && exp_q.size() != 0; i++) tick();
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    SoftReset_n    = 1'b0;
    af2cp_c1_valid = 1'b0;
    af2cp_c1_hdr   = '0;
    msix_ack       = 1'b0;
    rsp_stall      = 1'b0;
    tick();
    tick();
    check("rst_msix_req", 32'(msix_req), 32'd0);
    check("rst_vector", 32'(msix_vector), 32'd0);
    check("rst_almfull", 32'(c1TxAlmFull), 32'd0);
    check("rst_rspvalid", 32'(cp2af_c1_rspValid), 32'd0);
    check("rst_intr_cnt", intr_cnt, 32'd0);
    check("rst_ovf", 32'(ovf_err), 32'd0);
    SoftReset_n = 1'b1;
    tick();

    // 1: single interrupt id=2, vector = 4+2, ack three cycles after msix_req
    exp_q.push_back(2'd2);
    send(1'b1, 2'd2);
    check("t1_req_n1", 32'(msix_req), 32'd0);
    tick();
    check("t1_req_n2", 32'(msix_req), 32'd1);
    check("t1_vector", 32'(msix_vector), 32'd6);
    tick();
    tick();
    check("t1_req_hold", 32'(msix_req), 32'd1);
    check("t1_vector_hold", 32'(msix_vector), 32'd6);
    msix_ack = 1'b1;
    tick();
    msix_ack = 1'b0;
    check("t1_req_drop", 32'(msix_req), 32'd0);
    drain("t1_drain", 10);
    check("t1_cnt", intr_cnt, 32'd1);

    // 2: burst of 16 with immediate acks
    auto_ack     = 1'b1;
    almfull_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(2'(i % 4));
      send(1'b1, 2'(i % 4));
      almfull_seen |= c1TxAlmFull;
    end
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      tick();
      almfull_seen |= c1TxAlmFull;
    end
    check("t2_drain", 32'(exp_q.size()), 32'd0);
    check("t2_almfull_seen", 32'(almfull_seen), 32'd1);
    check("t2_ovf", 32'(ovf_err), 32'd0);
    check("t2_cnt", intr_cnt, 32'd17);
    tick();
    check("t2_almfull_clear", 32'(c1TxAlmFull), 32'd0);

    // 3: acks held off; one in flight plus 16 queued, the 18th is dropped
    auto_ack = 1'b0;
    msix_ack = 1'b0;
    for (int i = 0; i < 17; i++) begin
      exp_q.push_back(2'(i % 4));
      send(1'b1, 2'(i % 4));
    end
    check("t3_ovf_before", 32'(ovf_err), 32'd0);
    check("t3_almfull", 32'(c1TxAlmFull), 32'd1);
    send(1'b1, 2'd1);
    check("t3_ovf_set", 32'(ovf_err), 32'd1);
    auto_ack = 1'b1;
    drain("t3_drain", 300);
    tick();
    tick();
    check("t3_cnt", intr_cnt, 32'd34);
    check("t3_ovf_sticky", 32'(ovf_err), 32'd1);

    // 4: response stalled for five cycles with a second interrupt queued
    rsp_stall = 1'b1;
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd3);
    send(1'b1, 2'd1);
    send(1'b1, 2'd3);
    req_seen = 1'b0;
    for (int i = 0; i < 20 && !(req_seen && msix_req === 1'b0); i++) begin
      req_seen |= msix_req;
      tick();
    end
    check("t4_in_rsp", 32'(req_seen && msix_req === 1'b0), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("t4_stall_rspvalid", 32'(cp2af_c1_rspValid), 32'd0);
      check("t4_stall_no_req", 32'(msix_req), 32'd0);
      tick();
    end
    check("t4_stall_exp", 32'(exp_q.size()), 32'd2);
    rsp_stall = 1'b0;
    drain("t4_drain", 30);
    check("t4_cnt", intr_cnt, 32'd36);

    // 5: reset while in REQ discards everything in flight
    auto_ack = 1'b0;
    msix_ack = 1'b0;
    send(1'b1, 2'd0);
    send(1'b1, 2'd2);
    send(1'b1, 2'd3);
    for (int i = 0; i < 10 && msix_req !== 1'b1; i++) tick();
    check("t5_req_before", 32'(msix_req), 32'd1);
    #2 SoftReset_n = 1'b0;
    #1;
    check("t5_async_req", 32'(msix_req), 32'd0);
    check("t5_async_cnt", intr_cnt, 32'd0);
    check("t5_async_ovf", 32'(ovf_err), 32'd0);
    tick();
    SoftReset_n = 1'b1;
    auto_ack    = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("t5_no_req", 32'(msix_req), 32'd0);
      tick();
    end
    check("t5_cnt", intr_cnt, 32'd0);

    // 6: stray ack in IDLE, then write-line traffic interleaved with interrupts
    auto_ack = 1'b0;
    msix_ack = 1'b1;
    tick();
    msix_ack = 1'b0;
    tick();
    check("t6_stray_req", 32'(msix_req), 32'd0);
    check("t6_stray_cnt", intr_cnt, 32'd0);
    auto_ack = 1'b1;
    send(1'b0, 2'd0);
    exp_q.push_back(2'd1);
    send(1'b1, 2'd1);
    send(1'b0, 2'd3);
    send(1'b0, 2'd2);
    exp_q.push_back(2'd2);
    send(1'b1, 2'd2);
    exp_q.push_back(2'd0);
    send(1'b1, 2'd0);
    drain("t6_drain", 40);
    for (int i = 0; i < 6; i++) tick();
    check("t6_cnt", intr_cnt, 32'd3);
    check("t6_idle_req", 32'(msix_req), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
